uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: synchronises the UART receiver's done level, pushes each
// completed byte on done's falling edge into a first-word-fall-through FIFO.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_done,
  input  logic [7:0]      rx_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [7:0]      rd_data,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  input  logic            clear_ovf
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1'b1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(1'b0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              s3_q, s3_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [DEPTH];

  logic push_evt_s;
  logic pop_s;
  logic full_s;
  logic push_ok_s;

  // Next-state logic: done synchroniser, edge detect, pointers, occupancy, overrun flag.
  always_comb begin
    s1_d = rx_done;
    s2_d = s1_q;
    s3_d = s2_q;

    // Bytes complete on done's falling edge, the only point at which rx_data is fresh.
    push_evt_s = s3_q & ~s2_q;
    pop_s      = rd_valid_q & rd_ready;
    full_s     = (count_q == FULL_CNT);
    push_ok_s  = push_evt_s & (~full_s | pop_s);

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    rd_valid_d = (count_d != CNT_ZERO);

    if (push_evt_s & full_s & ~pop_s) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      count_q    <= CNT_ZERO;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; inputs change and outputs are
// sampled on the falling clock edge.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       overflow;
  logic       clear_ovf;

  int tests;
  int fails;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow),
    .clear_ovf(clear_ovf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise done for hi cycles, then drop it and present the byte; returns on the fall.
  task automatic frame(input logic [7:0] d, input int hi);
    rx_done = 1'b1;
    repeat (hi) @(negedge clk);
    rx_done = 1'b0;
    rx_data = d;
  endtask

  task automatic frame_wait(input logic [7:0] d);
    frame(d, 2);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    rd_ready  = 1'b0;
    clear_ovf = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_valid", {15'd0, rd_valid}, 16'd0);
    chk("reset_count", {11'd0, count}, 16'd0);
    chk("reset_ovf", {15'd0, overflow}, 16'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte with a long done pulse.
    frame(8'hA5, 200);
    chk("single_no_push_while_high", {11'd0, count}, 16'd0);
    @(negedge clk);
    chk("single_valid_e1", {15'd0, rd_valid}, 16'd0);
    @(negedge clk);
    chk("single_valid_e2", {15'd0, rd_valid}, 16'd0);
    @(negedge clk);
    chk("single_valid_e3", {15'd0, rd_valid}, 16'd1);
    chk("single_data", {8'd0, rd_data}, 16'h00A5);
    repeat (10) @(negedge clk);
    chk("single_one_push", {11'd0, count}, 16'd1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("single_drained", {11'd0, count}, 16'd0);

    // Streaming with the consumer always ready.
    rd_ready = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      frame(8'(b), 3);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rd_valid) break;
      end
      chk("stream_valid", {15'd0, rd_valid}, 16'd1);
      chk("stream_data", {8'd0, rd_data}, 16'(b));
      chk("stream_count", {11'd0, count}, 16'd1);
      @(negedge clk);
      chk("stream_popped", {11'd0, count}, 16'd0);
    end
    chk("stream_ovf", {15'd0, overflow}, 16'd0);
    rd_ready = 1'b0;

    // Fill and overrun: 17 bytes into 16 entries.
    for (int i = 0; i < 17; i++) frame_wait(8'(8'h10 + i));
    chk("fill_count", {11'd0, count}, 16'd16);
    chk("fill_ovf", {15'd0, overflow}, 16'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_drain", {7'd0, rd_valid, rd_data}, {7'd0, 1'b1, 8'(8'h10 + i)});
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("fill_empty_valid", {15'd0, rd_valid}, 16'd0);
    chk("fill_empty_count", {11'd0, count}, 16'd0);
    // rd_ready on an empty FIFO must not move the read pointer.
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rd_ready = 1'b0;
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("clear_ovf", {15'd0, overflow}, 16'd0);

    // Full with a pop in the push_evt cycle.
    for (int i = 0; i < 16; i++) frame_wait(8'(8'h40 + i));
    chk("full_count", {11'd0, count}, 16'd16);
    chk("full_head_after_empty_ready", {8'd0, rd_data}, 16'h0040);
    frame(8'h77, 2);
    @(negedge clk);
    @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("fullpop_count", {11'd0, count}, 16'd16);
    chk("fullpop_ovf", {15'd0, overflow}, 16'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fullpop_drain", {7'd0, rd_valid, rd_data},
          {7'd0, 1'b1, (i < 15) ? 8'(8'h41 + i) : 8'h77});
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("fullpop_empty", {11'd0, count}, 16'd0);

    // Overrun set wins over a same-cycle clear.
    for (int i = 0; i < 16; i++) frame_wait(8'(8'h50 + i));
    frame(8'h99, 2);
    @(negedge clk);
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("prio_ovf_set", {15'd0, overflow}, 16'd1);
    chk("prio_count", {11'd0, count}, 16'd16);
    chk("prio_head", {8'd0, rd_data}, 16'h0050);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("prio_ovf_clr", {15'd0, overflow}, 16'd0);
    rd_ready = 1'b1;
    repeat (16) @(negedge clk);
    rd_ready = 1'b0;
    chk("prio_drained", {11'd0, count}, 16'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) frame_wait(8'(8'h31 + i));
    chk("rst_pre_count", {11'd0, count}, 16'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {15'd0, rd_valid}, 16'd0);
    chk("rst_async_count", {11'd0, count}, 16'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    frame_wait(8'h3C);
    chk("rst_after_valid", {15'd0, rd_valid}, 16'd1);
    chk("rst_after_data", {8'd0, rd_data}, 16'h003C);
    chk("rst_after_count", {11'd0, count}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
